// File: rtl/signed_accumulator.sv
// signed_accumulator: sums a burst of signed operands into one wrapped result.
// Operands stream in over a valid/ready handshake and are added one per cycle
// through a single ripple-carry adder. The result leaves over a second
// valid/ready handshake, together with a sticky signed-overflow flag.

// rippleCarryAdder: WIDTH-bit ripple-carry adder with signed overflow detection.
module rippleCarryAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full-adder cell per bit; each cell's carry feeds the next.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    // Signed overflow is detected when the carry into the sign bit differs from the carry out of it.
    assign o_cout     = w_carry[WIDTH];
    assign o_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule

module signed_accumulator #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_len,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_in_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_out_sum,
    output logic               o_out_overflow,
    output logic               o_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_sum;
    logic               w_add_ovf;
    logic               w_cout_unused;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_beat;

    // The running total is the adder's first operand; every incoming beat is the second.
    rippleCarryAdder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a        (r_acc),
        .i_b        (i_in_data),
        .i_cin      (1'b0),
        .o_sum      (w_sum),
        .o_cout     (w_cout_unused),
        .o_overflow (w_add_ovf)
    );

    assign w_in_ready  = (r_state == ACCUM);
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_last_beat = (r_remaining == COUNT_W'(1));

    // Burst control: load on start, fold in accepted beats, hold the result until it is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_remaining <= i_len;
                        r_state     <= (i_len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_sum;
                        r_ovf       <= r_ovf | w_add_ovf;
                        r_remaining <= r_remaining - COUNT_W'(1);
                        if (w_last_beat) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result outputs come straight from registers, so they stay stable while DONE waits for out_ready.
    assign o_in_ready     = w_in_ready;
    assign o_out_valid    = (r_state == DONE);
    assign o_out_sum      = r_acc;
    assign o_out_overflow = r_ovf;
    assign o_busy         = (r_state == ACCUM) || (r_state == DONE);

endmodule
